// File: rtl/n64adv2_vinfo_demux.sv
// N64 VI input stage: rebuilds {sync, R, G, B} pixels from the 4-phase VI bus,
// measures lines per field and derives PAL / interlace flags with hysteresis.
module n64adv2_vinfo_demux #(
  parameter int color_width     = 7,
  parameter int linecnt_width   = 10,
  parameter int pal_line_thresh = 290,
  parameter int mode_confirm    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       nVDSYNC_i,
  input  logic [color_width-1:0]     VD_i,
  input  logic                       clr_err_i,
  output logic [3:0]                 sync_o,
  output logic [3*color_width-1:0]   vdata_o,
  output logic                       vdata_valid_o,
  output logic [linecnt_width-1:0]   linecnt_o,
  output logic                       palmode_o,
  output logic                       interlaced_o,
  output logic                       desync_err_o
);

  typedef enum logic [2:0] {PH_IDLE, PH_S, PH_R, PH_G, PH_B} phase_t;

  localparam int LW = linecnt_width;
  localparam int CW = color_width;
  localparam logic [LW-1:0] cnt_max   = '1;
  localparam logic [LW-1:0] cnt_one   = LW'(1);
  localparam logic [LW:0]   ext_one   = (LW+1)'(1);
  localparam logic [2:0]    agree_max = 3'd7;
  localparam logic [2:0]    agree_one = 3'd1;
  localparam logic [2:0]    confirm   = 3'(mode_confirm);

  phase_t        phase_reg, phase_next;
  logic          phase_err;
  logic [3:0]    sync_sh_reg;
  logic [CW-1:0] r_sh_reg, g_sh_reg, b_sh_reg;

  logic          vs_hist_reg, hs_hist_reg;
  logic          hs_fall, vs_fall;
  logic [LW-1:0] line_cnt_reg, line_inc, field_cnt, prev_cnt_reg;
  logic          have_prev_reg;
  logic          pal_cand, il_cand;
  logic          pal_cand_reg, il_cand_reg;
  logic [2:0]    pal_agree_reg, pal_agree_next;
  logic [2:0]    il_agree_reg, il_agree_next;
  logic          field_end_reg;

  // A low nVDSYNC_i always restarts the pixel; only B may legally see it.
  always_comb begin
    phase_next = phase_reg;
    phase_err  = 1'b0;
    if (!nVDSYNC_i) begin
      phase_next = PH_S;
      phase_err  = (phase_reg == PH_S) || (phase_reg == PH_R) || (phase_reg == PH_G);
    end else begin
      case (phase_reg)
        PH_S:    phase_next = PH_R;
        PH_R:    phase_next = PH_G;
        PH_G:    phase_next = PH_B;
        PH_B: begin
          phase_next = PH_IDLE;
          phase_err  = 1'b1;
        end
        default: phase_next = PH_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_reg   <= PH_IDLE;
      sync_sh_reg <= '0;
      r_sh_reg    <= '0;
      g_sh_reg    <= '0;
      b_sh_reg    <= '0;
    end else begin
      phase_reg <= phase_next;
      case (phase_next)
        PH_S:    sync_sh_reg <= VD_i[3:0];
        PH_R:    r_sh_reg    <= VD_i;
        PH_G:    g_sh_reg    <= VD_i;
        PH_B:    b_sh_reg    <= VD_i;
        default: ;
      endcase
    end
  end

  // Commit the whole pixel at once so sync_o and vdata_o are always coherent.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_o        <= '0;
      vdata_o       <= '0;
      vdata_valid_o <= 1'b0;
      desync_err_o  <= 1'b0;
    end else begin
      vdata_valid_o <= (phase_reg == PH_B);
      if (phase_reg == PH_B) begin
        sync_o  <= sync_sh_reg;
        vdata_o <= {r_sh_reg, g_sh_reg, b_sh_reg};
      end
      if (phase_err) begin
        desync_err_o <= 1'b1;
      end else if (clr_err_i) begin
        desync_err_o <= 1'b0;
      end
    end
  end

  always_comb begin
    hs_fall   = vdata_valid_o && hs_hist_reg && !sync_o[1];
    vs_fall   = vdata_valid_o && vs_hist_reg && !sync_o[3];
    line_inc  = (line_cnt_reg == cnt_max) ? cnt_max : line_cnt_reg + cnt_one;
    field_cnt = hs_fall ? line_inc : line_cnt_reg;
    pal_cand  = 32'(field_cnt) > 32'(pal_line_thresh);
    il_cand   = have_prev_reg &&
                (({1'b0, field_cnt} == {1'b0, prev_cnt_reg} + ext_one) ||
                 ({1'b0, prev_cnt_reg} == {1'b0, field_cnt} + ext_one));
    if (pal_cand != pal_cand_reg) begin
      pal_agree_next = agree_one;
    end else begin
      pal_agree_next = (pal_agree_reg == agree_max) ? agree_max : pal_agree_reg + agree_one;
    end
    if (il_cand != il_cand_reg) begin
      il_agree_next = agree_one;
    end else begin
      il_agree_next = (il_agree_reg == agree_max) ? agree_max : il_agree_reg + agree_one;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_hist_reg   <= 1'b0;
      hs_hist_reg   <= 1'b0;
      line_cnt_reg  <= '0;
      linecnt_o     <= '0;
      prev_cnt_reg  <= '0;
      have_prev_reg <= 1'b0;
      pal_cand_reg  <= 1'b0;
      il_cand_reg   <= 1'b0;
      pal_agree_reg <= '0;
      il_agree_reg  <= '0;
      field_end_reg <= 1'b0;
      palmode_o     <= 1'b0;
      interlaced_o  <= 1'b0;
    end else begin
      field_end_reg <= vs_fall;
      if (vdata_valid_o) begin
        vs_hist_reg <= sync_o[3];
        hs_hist_reg <= sync_o[1];
      end
      if (vs_fall) begin
        linecnt_o     <= field_cnt;
        line_cnt_reg  <= '0;
        prev_cnt_reg  <= field_cnt;
        have_prev_reg <= 1'b1;
        pal_cand_reg  <= pal_cand;
        il_cand_reg   <= il_cand;
        pal_agree_reg <= pal_agree_next;
        il_agree_reg  <= il_agree_next;
      end else if (hs_fall) begin
        line_cnt_reg <= line_inc;
      end
      // Flags follow a candidate only once it has held for mode_confirm fields.
      if (field_end_reg) begin
        if (pal_agree_reg >= confirm && pal_cand_reg != palmode_o) begin
          palmode_o <= pal_cand_reg;
        end
        if (il_agree_reg >= confirm && il_cand_reg != interlaced_o) begin
          interlaced_o <= il_cand_reg;
        end
      end
    end
  end

endmodule

// File: doc/n64adv2_vinfo_demux.md
Name: n64adv2_vinfo_demux

Overview:
- Parametrised successor of the N64 video input registering stage, sitting between the raw VI pins and the PPU/controller.
- Demultiplexes the 4-phase N64 VI bus (sync word, R, G, B) into one parallel pixel vector with a valid strobe.
- Also measures lines per field and derives PAL and interlace flags.
- Adds desync detection, configurable colour width and a configurable PAL line threshold.

Parameters:
- color_width, 7, bits per colour channel on VD_i and on each pixel output channel.
- linecnt_width, 10, width of the line counter and of the line-count outputs.
- pal_line_thresh, 290, field line count strictly above this value means PAL.
- mode_confirm, 2, number of consecutive identical mode decisions required before palmode_o or interlaced_o changes (range 1..7).

Ports:
- clk  in  1  N64 video clock.
- rst  in  1  synchronous reset, active-high.
- nVDSYNC_i  in  1  phase marker, low during the sync word.
- VD_i  in  color_width  VI data bus.
- clr_err_i  in  1  single-cycle clear for desync_err_o.
- sync_o  out  4  captured sync word {VSYNC, CLAMP, HSYNC, CSYNC} = VD_i[3:0]; all bits active-low.
- vdata_o  out  3*color_width  {R, G, B}.
- vdata_valid_o  out  1  one-cycle strobe; sync_o and vdata_o are coherent while it is high.
- linecnt_o  out  linecnt_width  lines counted in the last complete field.
- palmode_o  out  1  PAL detected.
- interlaced_o  out  1  interlaced detected.
- desync_err_o  out  1  sticky phase error.

Behaviour:
- Reset values: all outputs 0; phase = IDLE; internal counters and history 0.
- Phase FSM:
  - States: IDLE, S, R, G, B.
  - Any state with nVDSYNC_i = 0 goes to S and captures VD_i[3:0] into a sync shadow register.
  - S -> R, R -> G and G -> B when nVDSYNC_i = 1; each state captures VD_i into its channel shadow.
  - B with nVDSYNC_i = 1 goes to IDLE and sets desync_err_o (missing sync).
  - IDLE stays IDLE while nVDSYNC_i = 1.
  - nVDSYNC_i = 0 while in S, R or G: sets desync_err_o, discards the partial pixel, re-enters S.
- Output timing:
  - On the cycle the B channel is captured, the full shadow is transferred to sync_o and vdata_o on the next edge.
  - vdata_valid_o is high for exactly that one cycle.
  - Latency: first sync sample to valid output = 4 clocks.
  - sync_o and vdata_o hold their value between strobes.
- Line counter:
  - Edge detection runs on the committed sync_o only, sampled on vdata_valid_o.
  - HSYNC falling edge (prev 1, new 0) increments the line counter, saturating at all-ones.
  - VSYNC falling edge: linecnt_o <= counter (plus 1 if an HSYNC fall occurs on the same pixel); counter <= 0; the field-end event fires.
- Mode decision at each field end:
  - pal_cand = (field count > pal_line_thresh).
  - il_cand = (field count differs from the previous field count by exactly 1).
  - Each candidate has its own agreement counter. The counter resets to 1 when the candidate differs from the previous candidate, otherwise increments (saturating).
  - When agreement reaches mode_confirm and the candidate differs from the output, the output updates on the next clock.
  - The first field after reset has no previous count: il_cand = 0.
- desync_err_o:
  - Set-dominant: a simultaneous clr_err_i and a new error leaves it at 1.
  - Clear takes effect on the next clock.
- rst mid-pixel: the phase returns to IDLE, all shadows are cleared, and no valid strobe is produced for the partial pixel.

Test Plan:
1. Reset then a clean 4-phase stream, sync word 0xF then R=0x11, G=0x22, B=0x33 -> vdata_valid_o high 4 clocks after the sync sample, vdata_o = {0x11, 0x22, 0x33}, sync_o = 0xF, no error.
2. nVDSYNC_i low again during the G phase -> desync_err_o = 1, no valid strobe for that pixel, next full pixel valid. clr_err_i pulse -> error 0 the next cycle. clr_err_i coincident with a new error -> stays 1.
3. Fields of 263 lines each, repeated (mode_confirm = 2) -> linecnt_o = 263, palmode_o = 0, interlaced_o = 0.
4. Fields alternating 313/312 lines -> palmode_o = 1 and interlaced_o = 1 after the second agreeing decision, not after the first.
5. Field longer than 2^linecnt_width lines with linecnt_width = 4 -> linecnt_o = 15, saturated without wrap.
6. rst asserted in the R phase -> all outputs 0 the next cycle; the stream resumes, and the first valid strobe comes only after a fresh sync word.
